hazard_redirect_unit: RTL

Parametrised hazard and forwarding controller for the pipelined MIPS core, successor to the fixed 5-stage redirection logic. It keeps an internal scoreboard of the DEPTH stages downstream of decode, holding each stage's destination register and a result-latency countdown. From that scoreboard it derives:
- load-use and multi-cycle stalls;
- registered per-operand forwarding selects;
- multi-cycle fetch/decode flushes after taken jumps or branches.

It sits beside the ID stage and drives PC, IF/ID and ID/EX control.

---
 rtl/hazard_redirect_unit_if.sv | 46 ++++
 rtl/hazard_redirect_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hazard_redirect_unit_if.sv
// hazard_redirect_unit_if
// ID-side bundle for the hazard/redirect controller.
//   in_EN        global pipeline enable
//   in_J         taken jump/branch redirect
//   in_ID_VALID  ID holds a real instruction
//   in_RS/in_RT  ID source registers, qualified by in_USE_RS/in_USE_RT
//   in_WR/in_WE  ID destination register and its write enable
//   in_LOAD      ID instruction is a load
//   in_SYS       ID instruction is SYSCALL
//   out_PEN/out_BEN      PC and IF/ID enables
//   out_DECLR/out_FDCLR  ID/EX and IF/ID clears
//   out_FWDA/out_FWDB    registered EX operand forwarding selects
// slave: the controller; master: whoever drives the ID fields.
interface hazard_redirect_unit_if #(
  parameter int REG_AW = 5
);
  logic              in_EN;
  logic              in_J;
  logic              in_ID_VALID;
  logic [REG_AW-1:0] in_RS;
  logic [REG_AW-1:0] in_RT;
  logic              in_USE_RS;
  logic              in_USE_RT;
  logic [REG_AW-1:0] in_WR;
  logic              in_WE;
  logic              in_LOAD;
  logic              in_SYS;
  logic              out_PEN;
  logic              out_BEN;
  logic              out_DECLR;
  logic              out_FDCLR;
  logic [2:0]        out_FWDA;
  logic [2:0]        out_FWDB;

  modport master (
    output in_EN, in_J, in_ID_VALID, in_RS, in_RT, in_USE_RS, in_USE_RT,
           in_WR, in_WE, in_LOAD, in_SYS,
    input  out_PEN, out_BEN, out_DECLR, out_FDCLR, out_FWDA, out_FWDB
  );

  modport slave (
    input  in_EN, in_J, in_ID_VALID, in_RS, in_RT, in_USE_RS, in_USE_RT,
           in_WR, in_WE, in_LOAD, in_SYS,
    output out_PEN, out_BEN, out_DECLR, out_FDCLR, out_FWDA, out_FWDB
  );
endinterface

// File: rtl/hazard_redirect_unit.sv
// hazard_redirect_unit
// Hazard and forwarding controller beside the ID stage. Keeps a scoreboard of
// the DEPTH stages after ID (1 = EX .. DEPTH = WB), each entry holding valid,
// write-enable, destination and a remaining-latency countdown. From it the
// unit derives load-use / multi-cycle stalls, registered forwarding selects
// and a FLUSH_DEPTH-cycle IF/ID clear after each taken redirect.
// Ports:
//   in_CLK  clock, rising edge
//   in_RST  asynchronous reset, active-low
//   bus     hazard_redirect_unit_if.slave (ID fields in, pipeline control out)
// Optional feature: define REDI_SYSCALL_EN to make SYSCALL read $2 on operand
// A and $4 on operand B; otherwise in_SYS is ignored.
module hazard_redirect_unit #(
  parameter int DEPTH       = 3,
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 2,
  parameter int FLUSH_DEPTH = 1
) (
  input logic                  in_CLK,
  input logic                  in_RST,
  hazard_redirect_unit_if.slave bus
);

  localparam int CW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  // Latency countdown as an entry ages; never wraps below zero.
  function automatic logic [2:0] lat_dec_sat(input logic [2:0] lat);
    return (lat == 3'd0) ? 3'd0 : lat - 3'd1;
  endfunction

  function automatic logic src_match(input logic v, input logic we,
                                     input logic [REG_AW-1:0] dest,
                                     input logic [REG_AW-1:0] src,
                                     input logic use_src);
    return use_src && (src != '0) && v && we && (dest == src);
  endfunction

  logic [DEPTH:1]             valid_q, valid_d;
  logic [DEPTH:1]             we_q, we_d;
  logic [DEPTH:1][REG_AW-1:0] dest_q, dest_d;
  logic [DEPTH:1][2:0]        lat_q, lat_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [2:0]                 fwda_q, fwda_d;
  logic [2:0]                 fwdb_q, fwdb_d;

  logic [REG_AW-1:0] src_a, src_b;
  logic              use_a, use_b;
  logic [2:0]        sel_a, sel_b;
  logic [2:0]        lat_a, lat_b;
  logic              fdclr, stall, accept;

  // Effective source operands
`ifdef REDI_SYSCALL_EN
  always_comb begin
    src_a = bus.in_RS;
    src_b = bus.in_RT;
    use_a = bus.in_USE_RS;
    use_b = bus.in_USE_RT;
    if (bus.in_SYS && bus.in_ID_VALID) begin
      src_a = REG_AW'(2);
      src_b = REG_AW'(4);
      use_a = 1'b1;
      use_b = 1'b1;
    end
  end
`else
  wire unused_sys = bus.in_SYS;
  always_comb begin
    src_a = bus.in_RS;
    src_b = bus.in_RT;
    use_a = bus.in_USE_RS;
    use_b = bus.in_USE_RT;
  end
`endif

  // Youngest match: scan oldest to youngest so the smallest k overwrites.
  always_comb begin
    sel_a = 3'd0;
    sel_b = 3'd0;
    lat_a = 3'd0;
    lat_b = 3'd0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (src_match(valid_q[k], we_q[k], dest_q[k], src_a, use_a)) begin
        sel_a = 3'(k);
        lat_a = lat_q[k];
      end
      if (src_match(valid_q[k], we_q[k], dest_q[k], src_b, use_b)) begin
        sel_b = 3'(k);
        lat_b = lat_q[k];
      end
    end
  end

  // Control outputs; a redirect suppresses the stall so the flush wins.
  always_comb begin
    fdclr  = bus.in_J || (cnt_q != '0);
    stall  = bus.in_ID_VALID && !fdclr &&
             (((sel_a != 3'd0) && (lat_a > 3'd1)) ||
              ((sel_b != 3'd0) && (lat_b > 3'd1)));
    accept = bus.in_ID_VALID && !stall && !fdclr;
  end

  assign bus.out_PEN   = bus.in_EN && !stall;
  assign bus.out_BEN   = bus.in_EN && !stall;
  assign bus.out_DECLR = stall || fdclr;
  assign bus.out_FDCLR = fdclr;
  assign bus.out_FWDA  = fwda_q;
  assign bus.out_FWDB  = fwdb_q;

  // Next state: scoreboard shift, flush counter, forwarding selects
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    dest_d  = dest_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    fwda_d  = fwda_q;
    fwdb_d  = fwdb_q;
    if (bus.in_EN) begin
      for (int k = DEPTH; k >= 2; k--) begin
        valid_d[k] = valid_q[k-1];
        we_d[k]    = we_q[k-1];
        dest_d[k]  = dest_q[k-1];
        lat_d[k]   = lat_dec_sat(lat_q[k-1]);
      end
      valid_d[1] = accept;
      we_d[1]    = accept && bus.in_WE;
      dest_d[1]  = bus.in_WR;
      lat_d[1]   = bus.in_LOAD ? 3'(LOAD_LAT) : 3'd1;
      fwda_d     = accept ? sel_a : 3'd0;
      fwdb_d     = accept ? sel_b : 3'd0;
      if (bus.in_J) begin
        cnt_d = CW'(FLUSH_DEPTH - 1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Control state: cleared asynchronously
  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      valid_q <= '0;
      we_q    <= '0;
      cnt_q   <= '0;
      fwda_q  <= 3'd0;
      fwdb_q  <= 3'd0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      fwda_q  <= fwda_d;
      fwdb_q  <= fwdb_d;
    end
  end

  // Entry payload: only meaningful while its valid bit is set
  always_ff @(posedge in_CLK) begin
    dest_q <= dest_d;
    lat_q  <= lat_d;
  end

endmodule
